// File: rtl/wbc_arbiter_if.sv
// Bus bundle between the three WISHBONE masters' CYC/STB lines, the slave-mux
// termination and the round-robin arbiter with its watchdog outputs.
interface wbc_arbiter_if;
  logic [2:0]  cyc_i;
  logic [2:0]  stb_i;
  logic        term_i;
  logic [2:0]  gnt_o;
  logic        timeout_o;
  logic        busy_o;
  logic [15:0] timeout_cnt_o;

  modport slave (
    input  cyc_i, stb_i, term_i,
    output gnt_o, timeout_o, busy_o, timeout_cnt_o
  );

  modport master (
    output cyc_i, stb_i, term_i,
    input  gnt_o, timeout_o, busy_o, timeout_cnt_o
  );
endinterface

// File: rtl/wbc_arbiter.sv
// Three-master round-robin WISHBONE arbiter with a one-cycle dead gap between
// grants and a stalled-strobe watchdog that forces a bus error on expiry.
module wbc_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  wbc_arbiter_if.slave   bus
);
  localparam int unsigned NM  = 3;
  localparam int unsigned IW  = 2;
  localparam int unsigned WDW = 16;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TIMEOUT, S_GAP} state_e;

  state_e         state_q, state_d;
  logic [NM-1:0]  gnt_q, gnt_d;
  logic           to_q, to_d;
  logic           busy_q, busy_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [WDW-1:0] cnt_q, cnt_d;
  logic [IW-1:0]  last_q, last_d;

  logic [IW-1:0]  pick_c;
  logic           g_cyc_c;
  logic           g_stb_c;

  assign g_cyc_c = |(bus.cyc_i & gnt_q);
  assign g_stb_c = |(bus.stb_i & gnt_q);

  // Round-robin search starting just after the last granted master.
  always_comb begin
    logic [IW-1:0] cand;
    logic          found;
    pick_c = last_q;
    cand   = '0;
    found  = 1'b0;
    for (int unsigned k = 1; k <= NM; k++) begin
      cand = IW'((32'(last_q) + k) % NM);
      if (!found && bus.cyc_i[cand]) begin
        pick_c = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    to_d    = 1'b0;
    wd_d    = '0;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_GAP: begin
        gnt_d   = '0;
        state_d = S_IDLE;
        if (|bus.cyc_i) begin
          gnt_d   = NM'(1) << pick_c;
          last_d  = pick_c;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!g_cyc_c) begin
          gnt_d   = '0;
          state_d = S_GAP;
        end else if (bus.term_i || !g_stb_c) begin
          wd_d = '0;
        end else if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_TIMEOUT;
          to_d    = 1'b1;
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + WDW'(1);
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      S_TIMEOUT: begin
        if (g_cyc_c) begin
          state_d = S_GRANT;
        end else begin
          gnt_d   = '0;
          state_d = S_GAP;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = |gnt_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
      wd_q    <= '0;
      cnt_q   <= '0;
      last_q  <= IW'(2);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign bus.gnt_o         = gnt_q;
  assign bus.timeout_o     = to_q;
  assign bus.busy_o        = busy_q;
  assign bus.timeout_cnt_o = cnt_q;
endmodule

// File: tb/tb_wbc_arbiter.sv
// Scoreboard bench for wbc_arbiter: a transaction-level owner/stall model
// predicts each cycle's registered outputs; a monitor compares them.
module tb_wbc_arbiter;
  localparam int TO = 8;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wbc_arbiter_if bus();

  wbc_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [2:0]  gnt;
    logic        to;
    logic        busy;
    logic [15:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [2:0] got_q[$];
  logic [2:0] prev_gnt = 3'b000;
  bit         seen_to  = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  // Model: owner of the bus (-1 = none), last winner, stall run length.
  int m_owner, m_last, m_stall, m_cnt;
  bit m_to;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void model_reset();
    m_owner = -1; m_last = 2; m_stall = 0; m_to = 1'b0; m_cnt = 0;
  endfunction

  function automatic void model_step(input logic [2:0] c, input logic [2:0] s, input logic t);
    if (m_owner < 0) begin
      for (int k = 1; k <= 3; k++) begin
        int i;
        i = (m_last + k) % 3;
        if (c[i]) begin
          m_owner = i; m_last = i; m_stall = 0;
          break;
        end
      end
    end else if (m_to) begin
      m_to = 1'b0; m_stall = 0;
      if (!c[m_owner]) m_owner = -1;
    end else if (!c[m_owner]) begin
      m_owner = -1; m_stall = 0;
    end else if (t || !s[m_owner]) begin
      m_stall = 0;
    end else if (m_stall == TO - 1) begin
      m_to = 1'b1; m_stall = 0;
      if (m_cnt < 65535) m_cnt++;
    end else begin
      m_stall++;
    end
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.gnt  = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
    e.to   = m_to;
    e.busy = (m_owner >= 0);
    e.cnt  = 16'(m_cnt);
    exp_q.push_back(e);
  endfunction

  task automatic step(input logic [2:0] c, input logic [2:0] s, input logic t);
    @(negedge clk);
    rst_n      = 1'b1;
    bus.cyc_i  = c;
    bus.stb_i  = s;
    bus.term_i = t;
    model_step(c, s, t);
    push_exp();
  endtask

  task automatic hit_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_gnt",  32'(bus.gnt_o), 32'd0);
    chk("rst_to",   32'(bus.timeout_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_cnt",  32'(bus.timeout_cnt_o), 32'd0);
    model_reset();
    push_exp();
  endtask

  // Monitor: pops one prediction per clock and compares all outputs.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("gnt",      32'(bus.gnt_o), 32'(mon_e.gnt));
      chk("timeout",  32'(bus.timeout_o), 32'(mon_e.to));
      chk("busy",     32'(bus.busy_o), 32'(mon_e.busy));
      chk("to_count", 32'(bus.timeout_cnt_o), 32'(mon_e.cnt));
    end
    if (bus.gnt_o != 3'b000 && bus.gnt_o != prev_gnt) got_q.push_back(bus.gnt_o);
    prev_gnt = bus.gnt_o;
    if (bus.timeout_o) seen_to = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    logic [2:0] c, rc, rs;
    int         held;
    int         exp_order[4];
    exp_order = '{1, 2, 4, 1};

    rst_n = 1'b0;
    bus.cyc_i = 3'b000; bus.stb_i = 3'b000; bus.term_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    hit_reset();

    // Single master 1 transfer, then termination with no grant active.
    step(3'b010, 3'b010, 1'b0);
    repeat (3) step(3'b010, 3'b000, 1'b0);
    step(3'b000, 3'b000, 1'b0);
    repeat (2) step(3'b000, 3'b000, 1'b1);

    // All masters requesting; each drops after three granted cycles.
    hit_reset();
    got_q.delete();
    held = 0;
    for (int n = 0; n < 18; n++) begin
      held = (m_owner >= 0) ? held + 1 : 0;
      c = 3'b111;
      if (held == 3) c[m_owner] = 1'b0;
      step(c, 3'b000, 1'b0);
    end
    repeat (2) step(3'b000, 3'b000, 1'b0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_order_%0d", i),
          (i < got_q.size()) ? 32'(got_q[i]) : 32'd0, 32'(exp_order[i]));

    // term_i on the 8th stalled cycle beats expiry.
    hit_reset();
    seen_to = 1'b0;
    step(3'b001, 3'b001, 1'b0);
    repeat (7) step(3'b001, 3'b001, 1'b0);
    step(3'b001, 3'b001, 1'b1);
    repeat (3) step(3'b001, 3'b001, 1'b0);
    repeat (2) step(3'b000, 3'b000, 1'b0);
    chk("term_wins_no_timeout", 32'(seen_to), 32'd0);
    chk("term_wins_cnt", 32'(bus.timeout_cnt_o), 32'd0);

    // Uninterrupted stall: timeout on the 9th stalled cycle.
    step(3'b001, 3'b001, 1'b0);
    repeat (9) step(3'b001, 3'b001, 1'b0);
    repeat (2) step(3'b000, 3'b000, 1'b0);
    chk("expiry_seen", 32'(seen_to), 32'd1);
    chk("expiry_cnt", 32'(bus.timeout_cnt_o), 32'd1);

    // Reset during a master 2 grant, then masters 0 and 2 request.
    hit_reset();
    repeat (3) step(3'b100, 3'b000, 1'b0);
    hit_reset();
    step(3'b101, 3'b000, 1'b0);
    step(3'b101, 3'b000, 1'b0);
    chk("post_reset_first", 32'(bus.gnt_o), 32'd1);
    repeat (2) step(3'b000, 3'b000, 1'b0);

    // Randomized traffic.
    hit_reset();
    rc = 3'b000;
    for (int n = 0; n < 2500; n++) begin
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(9) == 0) rc[b] = ~rc[b];
        rs[b] = ($urandom_range(4) != 0);
      end
      if ($urandom_range(599) == 0) hit_reset();
      else step(rc, rs, ($urandom_range(9) == 0));
    end
    repeat (3) step(3'b000, 3'b000, 1'b0);
    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wbc_arbiter.md
WBC_ARBITER -- requirements
Module: wbc_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023: stalled-strobe cycles before a forced bus error (legal range 2..65535).
REQ-002 clk_i  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-004 cyc_i  input  3  WISHBONE CYC from masters 0 (pcic), 1 (turfc), 2 (hkmc).
REQ-005 stb_i  input  3  WISHBONE STB from the same masters.
REQ-006 term_i  input  1  OR of ACK/ERR/RTY from the address-decoded slave mux.
REQ-007 gnt_o  output  3  registered one-hot grant, or all-zero.
REQ-008 timeout_o  output  1  one-cycle forced ERR to the granted master.
REQ-009 busy_o  output  1  high whenever any gnt_o bit is high.
REQ-010 timeout_cnt_o  output  16  saturating count of timeout events.

Function
REQ-011 FSM states: IDLE, GRANT, TIMEOUT, GAP; every output is registered.
REQ-012 IDLE: gnt_o=0; any cyc_i bit high in cycle N -> gnt_o one-hot in cycle N+1, state GRANT.
REQ-013 Round-robin order: search starts at (last+1) mod 3, wraps 2->0; first requester found wins.
REQ-014 last pointer loads the granted index at each grant; it resets to 2 so master 0 has first priority.
REQ-015 GRANT: gnt_o holds while the granted cyc_i stays high; other requesters are ignored.
REQ-016 Granted cyc_i low in cycle N -> gnt_o=0 in cycle N+1, state GAP.
REQ-017 GAP lasts exactly one cycle with gnt_o=0.
REQ-018 GAP exit: next grant uses REQ-013 arbitration; gnt_o asserts in the following cycle with no further gap.
REQ-019 Watchdog counter (16 bit) increments each GRANT cycle with granted stb_i=1 and term_i=0.
REQ-020 Watchdog clears on term_i=1, on granted stb_i=0, and on every state exit.
REQ-021 Watchdog expiry: counter reaches TIMEOUT_CYCLES-1 and term_i=0 in the same cycle -> state TIMEOUT next cycle.
REQ-022 TIMEOUT: timeout_o=1 for exactly one cycle, gnt_o unchanged, timeout_cnt_o increments, saturating at 0xFFFF.
REQ-023 TIMEOUT exit: granted cyc_i high -> GRANT with watchdog cleared; cyc_i low -> GAP.
REQ-024 term_i coinciding with the expiry cycle: term_i wins; no timeout, counter clears.
REQ-025 term_i with no grant active is ignored.
REQ-026 cyc_i changes on non-granted masters never affect gnt_o during GRANT or TIMEOUT.
REQ-027 All three cyc_i high continuously, each cycle dropped after service: grants rotate 0,1,2,0,...

Reset
REQ-028 rst_n_i low -> immediately: gnt_o=0, timeout_o=0, busy_o=0, state IDLE, watchdog=0, last=2.
REQ-029 timeout_cnt_o resets to 0x0000 and is cleared only by reset.
REQ-030 Reset mid-transfer drops the grant asynchronously; after release, arbitration restarts per REQ-012 from last=2.

Verification
REQ-031 Master 1 cyc_i only, from IDLE in cycle N -> gnt_o=3'b010 in N+1; cyc_i low in M -> gnt_o=0 in M+1.
REQ-032 All cyc_i high; each master holds cyc_i 3 cycles after its grant, then drops it -> grant order 001,010,100,001, one zero gap cycle between grants.
REQ-033 TIMEOUT_CYCLES=8; master 0 granted with stb_i=1, term_i=0 -> timeout_o pulses 1 cycle on the 9th stalled cycle; timeout_cnt_o=1.
REQ-034 TIMEOUT_CYCLES=8; term_i=1 on the 8th stalled cycle -> no timeout_o; timeout_cnt_o stays 0.
REQ-035 rst_n_i low during master 2 grant -> gnt_o=0 same cycle; after release, masters 0 and 2 requesting -> master 0 granted first.
